// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges two write requesters into one register-file write port.
// Each requester feeds its own 2-entry {reg, data} FIFO. Non-empty FIFOs are
// arbitrated round-robin, and at most one head per cycle is registered onto
// the rf_* write port.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   a_valid/a_ready/a_reg/a_data  requester A write handshake
//   b_valid/b_ready/b_reg/b_data  requester B write handshake
//   rf_we[1:0]                  2'b01 = write this cycle, 2'b00 = idle
//   rf_waddr, rf_wdata          write address/data (held between writes)
//   rd1_addr, rd2_addr          read addresses to check against pending writes
//   hazard1, hazard2            combinational: read address has a pending write
//   idle                        both FIFOs empty and no write on the port
//
// Build option: define RF_ZERO_GUARD_EN to accept and silently drop writes to
// register 0, and to suppress hazards on reads of register 0.
module rf_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic [1:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  rd1_addr,
  input  logic [4:0]  rd2_addr,
  output logic        hazard1,
  output logic        hazard2,
  output logic        idle
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NPORT  = 2;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;

  localparam logic [1:0] WE_WRITE = 2'b01;
  localparam logic [1:0] WE_NONE  = 2'b00;

  typedef struct packed {
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] dat;
  } wr_entry_t;

  wr_entry_t              in_entry [NPORT];
  logic [NPORT-1:0]       in_valid;
  logic [NPORT-1:0]       ready;
  logic [NPORT-1:0]       push;
  logic [NPORT-1:0]       pop;
  logic [NPORT-1:0]       nonempty;
  logic [DEPTH-1:0]       slot_valid [NPORT];

  wr_entry_t              fifo_mem [NPORT][DEPTH];
  logic [NPORT-1:0]       wptr;
  logic [NPORT-1:0]       rptr;
  logic [CNT_W-1:0]       count [NPORT];
  logic                   last_b;
  wr_entry_t              head;

  // Gather both requesters into port-indexed arrays (0 = A, 1 = B).
  always_comb begin
    in_valid    = {b_valid, a_valid};
    in_entry[0] = '{rg: a_reg, dat: a_data};
    in_entry[1] = '{rg: b_reg, dat: b_data};
  end

  // FIFO status; ready depends on registered occupancy only, so a full FIFO
  // never accepts even in a cycle where it is also being popped.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int p = 0; p < NPORT; p++) begin
      slot_valid[p] = '0;
      ready[p]      = (count[p] != CNT_W'(DEPTH));
      nonempty[p]   = (count[p] != '0);
`ifdef RF_ZERO_GUARD_EN
      // Handshake still completes; register-0 entries just never get stored.
      push[p]       = in_valid[p] & ready[p] & (in_entry[p].rg != '0);
`else
      push[p]       = in_valid[p] & ready[p];
`endif
      for (int i = 0; i < DEPTH; i++) begin
        slot_valid[p][i] = (rptr[p] == 1'(i)) ? nonempty[p]
                                              : (count[p] == CNT_W'(DEPTH));
      end
    end
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];

  // Round-robin: on a tie, the port that did not win last time is granted.
  always_comb begin
    pop = '0;
    if (&nonempty) begin
      pop = last_b ? 2'b01 : 2'b10;
    end else begin
      pop = nonempty;
    end
    head = pop[1] ? fifo_mem[1][rptr[1]] : fifo_mem[0][rptr[0]];
  end

  // FIFO payload storage; validity is tracked by the reset pointers/counts.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (push[p]) begin
        fifo_mem[p][wptr[p]] <= in_entry[p];
      end
    end
  end

  // FIFO pointers, grant history and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      for (int p = 0; p < NPORT; p++) begin
        count[p] <= '0;
      end
      last_b   <= 1'b1;
      rf_we    <= WE_NONE;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (push[p]) begin
          wptr[p] <= ~wptr[p];
        end
        if (pop[p]) begin
          rptr[p] <= ~rptr[p];
        end
        count[p] <= count[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      end
      if (|pop) begin
        rf_we    <= WE_WRITE;
        rf_waddr <= head.rg;
        rf_wdata <= head.dat;
        last_b   <= pop[1];
      end else begin
        rf_we    <= WE_NONE;
      end
    end
  end

  // Read-after-write hazard: any stored entry or the write on the port now.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid[p][i]) begin
          if (fifo_mem[p][i].rg == rd1_addr) hazard1 = 1'b1;
          if (fifo_mem[p][i].rg == rd2_addr) hazard2 = 1'b1;
        end
      end
    end
    if (rf_we == WE_WRITE) begin
      if (rf_waddr == rd1_addr) hazard1 = 1'b1;
      if (rf_waddr == rd2_addr) hazard2 = 1'b1;
    end
`ifdef RF_ZERO_GUARD_EN
    if (rd1_addr == '0) hazard1 = 1'b0;
    if (rd2_addr == '0) hazard2 = 1'b0;
`endif
  end

  assign idle = ~|nonempty && (rf_we == WE_NONE);

endmodule
